// File: rtl/bdpsk_pkg.sv
// Shared BDPSK definitions: sample/carrier geometry, receiver states, sample format helper.
package bdpsk_pkg;

  localparam int unsigned DW          = 8;
  localparam int unsigned CARRIER_LEN = 128;
  localparam int unsigned WIN_LEN     = 64;

  localparam int unsigned PW     = 2 * DW;
  localparam int unsigned ACC_W  = PW + $clog2(WIN_LEN);
  localparam int unsigned PTR_W  = $clog2(CARRIER_LEN);
  localparam int unsigned FILL_W = $clog2(CARRIER_LEN + 1);
  localparam int unsigned WIN_W  = $clog2(WIN_LEN);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Offset-binary (mid-scale = 0) to two's complement: invert the MSB.
  function automatic logic signed [DW-1:0] offset_to_signed(input logic [DW-1:0] x);
    return {~x[DW-1], x[DW-2:0]};
  endfunction

endpackage

// File: rtl/bdpsk_decoder_sample_delay_line.sv
// One-carrier-period sample delay: circular buffer with registered read-before-write.
module sample_delay_line
  import bdpsk_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout
);

  logic signed [DW-1:0] mem [CARRIER_LEN];
  logic [PTR_W-1:0]     ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (ptr == PTR_W'(CARRIER_LEN - 1)) begin
      ptr <= '0;
    end else begin
      ptr <= ptr + PTR_W'(1);
    end
  end

  // dout returns the sample written to this slot CARRIER_LEN clocks earlier.
  always_ff @(posedge clk) begin
    mem[ptr] <= din;
    dout     <= mem[ptr];
  end

endmodule

// File: rtl/bdpsk_decoder.sv
// BDPSK receiver: delay-and-multiply detection, windowed integrate-and-dump,
// reversal thresholding with post-detection blanking.
module bdpsk_decoder
  import bdpsk_pkg::*;
#(
  parameter int   THRESH    = 131072,
  parameter int   BLANK_WIN = 2,
  parameter logic DATA_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] adc_data,
  output logic          clk_AD,
  output logic          dataout,
  output logic          rev_pulse,
  output logic          locked
);

  localparam int unsigned BLK_W = (BLANK_WIN < 2) ? 1 : $clog2(BLANK_WIN + 1);
  localparam logic signed [ACC_W-1:0] NEG_THRESH = ACC_W'(-THRESH);
  localparam state_t POST_REV = (BLANK_WIN == 0) ? RUN : BLANK;

  state_t                   state_q, state_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic [WIN_W-1:0]         win_q, win_d;
  logic [BLK_W-1:0]         blank_q, blank_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_add;
  logic                     dout_d, pulse_d;
  logic signed [DW-1:0]     s_q, d_del;
  logic signed [PW-1:0]     prod;
  logic                     is_dump;

  assign clk_AD = clk;

  sample_delay_line u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (offset_to_signed(adc_data)),
    .dout    (d_del)
  );

  // s_q and d_del are both one register past the ADC, so they stay aligned.
  assign prod    = PW'(s_q) * PW'(d_del);
  assign is_dump = (win_q == WIN_W'(WIN_LEN - 1));
  assign acc_add = (win_q == '0) ? ACC_W'(prod) : acc_q + ACC_W'(prod);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    win_d   = win_q;
    blank_d = blank_q;
    acc_d   = acc_q;
    dout_d  = dataout;
    pulse_d = 1'b0;
    unique case (state_q)
      FILL: begin
        acc_d = '0;
        win_d = '0;
        if (fill_q == FILL_W'(CARRIER_LEN)) begin
          state_d = RUN;
        end else begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
      RUN, BLANK: begin
        acc_d = acc_add;
        win_d = is_dump ? '0 : win_q + WIN_W'(1);
        if (is_dump) begin
          if (state_q == RUN) begin
            if (acc_add < NEG_THRESH) begin
              dout_d  = ~dataout;
              pulse_d = 1'b1;
              state_d = POST_REV;
              blank_d = BLK_W'(BLANK_WIN);
            end
          end else begin
            // Blanked dump: count it off, resume comparing after the last one.
            blank_d = blank_q - BLK_W'(1);
            if (blank_q <= BLK_W'(1)) begin
              state_d = RUN;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FILL;
      fill_q    <= '0;
      win_q     <= '0;
      blank_q   <= '0;
      acc_q     <= '0;
      s_q       <= '0;
      dataout   <= DATA_INIT;
      rev_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      win_q     <= win_d;
      blank_q   <= blank_d;
      acc_q     <= acc_d;
      s_q       <= offset_to_signed(adc_data);
      dataout   <= dout_d;
      rev_pulse <= pulse_d;
      locked    <= (state_d != FILL);
    end
  end

endmodule

// File: tb/tb_bdpsk_decoder.sv
// Randomised BDPSK receive bench: transmit model feeds the decoder, a window-sum
// reference predicts reversal events into a queue that a monitor consumes.
module tb_bdpsk_decoder;
  import bdpsk_pkg::*;

  localparam int   THRESH_TB = 131072;
  localparam int   BLANK_TB  = 2;
  localparam logic DINIT     = 1'b0;
  localparam int   LOCK_EDGE = CARRIER_LEN + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] adc_data = 8'd128;
  logic          clk_AD, dataout, rev_pulse, locked;

  bdpsk_decoder #(
    .THRESH    (THRESH_TB),
    .BLANK_WIN (BLANK_TB),
    .DATA_INIT (DINIT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .adc_data  (adc_data),
    .clk_AD    (clk_AD),
    .dataout   (dataout),
    .rev_pulse (rev_pulse),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Clock edges since reset release; edge n captures sample n.
  int ecnt = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  typedef struct packed { int at; logic data; } ev_t;
  ev_t exp_q[$];

  // Reference: windows of WIN_LEN products s[n]*s[n-CARRIER_LEN], first window
  // starting at sample CARRIER_LEN+1; event visible after edge (last sample + 1).
  int     n;
  int     hist [CARRIER_LEN];
  longint wsum;
  int     wcnt;
  int     blank;
  logic   mdata;

  task automatic model_reset();
    n = 0; wsum = 0; wcnt = 0; blank = 0; mdata = DINIT;
    exp_q.delete();
  endtask

  task automatic step(input int val);
    int s;
    adc_data = DW'(val);
    n++;
    s = val - 128;
    if (n > CARRIER_LEN) begin
      wsum += longint'(s) * longint'(hist[n % CARRIER_LEN]);
      wcnt++;
      if (wcnt == WIN_LEN) begin
        if (blank > 0) blank--;
        else if (wsum < -longint'(THRESH_TB)) begin
          mdata = ~mdata;
          exp_q.push_back('{at: n + 1, data: mdata});
          blank = BLANK_TB;
        end
        wsum = 0;
        wcnt = 0;
      end
    end
    hist[n % CARRIER_LEN] = s;
    @(posedge clk);
    #1;
  endtask

  // Transmit model: sine table, phase flips by half a period on each data change.
  int   sin_tbl [CARRIER_LEN];
  int   ph, amp, noise;
  logic tx_bit;

  function automatic int sample_of(input int p);
    int r;
    r = (sin_tbl[p] * amp) / 127;
    if (noise > 0) r = r + int'($urandom_range(2 * noise)) - noise;
    r = r + 128;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic tx_init(input logic b, input int a);
    tx_bit = b; ph = 0; amp = a; noise = 0;
  endtask

  task automatic tx(input logic b, input int count);
    for (int i = 0; i < count; i++) begin
      if (b != tx_bit) begin
        ph = (ph + CARRIER_LEN / 2) % CARRIER_LEN;
        tx_bit = b;
      end
      step(sample_of(ph));
      ph = (ph + 1) % CARRIER_LEN;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("reset_dataout", dataout, DINIT);
    check("reset_rev_pulse", rev_pulse, 0);
    check("reset_locked", locked, 0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: pops expected events when due and checks outputs every cycle.
  int   pulses = 0;
  int   last_pulse = 0;
  logic exp_dout = DINIT;
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_dout = DINIT;
    end else begin
      if (rev_pulse) begin
        pulses++;
        last_pulse = ecnt;
      end
      if (exp_q.size() > 0 && exp_q[0].at == ecnt) begin
        check("rev_pulse_expected", rev_pulse, 1);
        exp_dout = exp_q[0].data;
        void'(exp_q.pop_front());
      end else begin
        check("rev_pulse_idle", rev_pulse, 0);
      end
      check("dataout", dataout, exp_dout);
      check("locked", locked, ecnt >= LOCK_EDGE);
    end
  end

  int p0;

  initial begin
    for (int i = 0; i < CARRIER_LEN; i++) begin
      real v;
      v = 127.0 * $sin(6.283185307179586 * real'(i) / real'(CARRIER_LEN));
      sin_tbl[i] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    end
    #2;

    // 1: constant data, lock and silence
    do_reset(3); tx_init(1'b0, 127); p0 = pulses;
    tx(1'b0, 128);
    check("t1_locked_before", locked, 0);
    tx(1'b0, 1);
    check("t1_locked_after", locked, 1);
    tx(1'b0, 2048 - 129);
    check("t1_pulses", pulses - p0, 0);
    check("t1_dataout", dataout, 0);

    // 2: single rising edge at clk 1024
    do_reset(3); tx_init(1'b0, 127); p0 = pulses;
    tx(1'b0, 1024); tx(1'b1, 1024);
    check("t2_pulses", pulses - p0, 1);
    check("t2_dataout", dataout, 1);
    check("t2_latency_ok", (last_pulse - 1024) <= 3 * WIN_LEN + 2, 1);

    // 3: pattern 1,0,1,1,0 after a preamble of 1
    do_reset(3); tx_init(1'b1, 127); p0 = pulses;
    tx(1'b1, 1024);
    tx(1'b1, 512); tx(1'b0, 512); tx(1'b1, 512); tx(1'b1, 512); tx(1'b0, 512);
    tx(1'b0, 256);
    check("t3_pulses", pulses - p0, 3);
    check("t3_dataout", dataout, 1);

    // 4: mid-scale input, then a weak carrier with a reversal
    do_reset(3); tx_init(1'b0, 0); p0 = pulses;
    tx(1'b0, 1024);
    amp = 16;
    tx(1'b0, 512); tx(1'b1, 512); tx(1'b1, 256);
    check("t4_pulses", pulses - p0, 0);
    check("t4_dataout", dataout, 0);

    // 5: reversal inside the fill period
    do_reset(3); tx_init(1'b0, 127); p0 = pulses;
    tx(1'b0, 64); tx(1'b1, 64);
    check("t5_fill_pulses", pulses - p0, 0);
    check("t5_fill_dataout", dataout, DINIT);
    tx(1'b1, 896);

    // 6: reset mid-stream at clk 1500
    do_reset(3); tx_init(1'b0, 127);
    tx(1'b0, 1024); tx(1'b1, 476);
    check("t6_dataout_before_reset", dataout, 1);
    do_reset(3);
    tx(1'b1, 128);
    check("t6_relock_before", locked, 0);
    tx(1'b1, 1);
    check("t6_relock_after", locked, 1);
    tx(1'b1, 600);

    // 7: random bits, amplitude and noise
    for (int r = 0; r < 5; r++) begin
      int amps [4];
      amps = '{127, 96, 64, 16};
      do_reset(int'($urandom_range(1, 4)));
      tx_init(1'($urandom_range(1)), amps[$urandom_range(3)]);
      noise = int'($urandom_range(3));
      tx(tx_bit, 1024);
      for (int b = 0; b < 6; b++) begin
        tx(1'($urandom_range(1)), 384 + 128 * int'($urandom_range(3)));
      end
      tx(tx_bit, 256);
    end

    repeat (4) @(posedge clk);
    check("pending_expected_pulses", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
